// File: rtl/umem_pkg.sv
// Shared constants for the user-memory controller: FSM encoding, CPU rw encoding
// and the wait-state counter width.
package umem_pkg;

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/umem_if.sv
// Request/acknowledge bus between the CPU user-memory port (master) and a
// umem_ctrl instance (slave).
interface umem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              ack;
    logic              err;

    modport master (
        output req, rw, addr, wdata,
        input  rdata, ready, ack, err
    );

    modport slave (
        input  req, rw, addr, wdata,
        output rdata, ready, ack, err
    );
endinterface

// File: rtl/umem_array.sv
// Single-port DEPTH x DATA_W storage: synchronous write, asynchronous read.
// Addresses at or beyond DEPTH never write and read back as zero.
module umem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;

    assign w_idx      = i_addr[IDX_W-1:0];
    assign w_in_range = ({1'b0, i_addr} < DEPTH_V);

    always_ff @(posedge clk) begin
        if (i_we && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = w_in_range ? r_mem[w_idx] : '0;
endmodule

// File: rtl/umem_ctrl.sv
// User data memory controller: req/ack slave with programmable wait states,
// out-of-range error reporting and an optional post-reset clear sweep.
module umem_ctrl
    import umem_pkg::*;
#(
    parameter int              DATA_W         = 8,
    parameter int              ADDR_W         = 8,
    parameter int              DEPTH          = 256,
    parameter int              WAIT_STATES    = 1,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic  clk,
    input  logic  reset,
    umem_if.slave bus
);
    localparam logic [ADDR_W:0]   LAST_PTR  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);
    localparam logic [1:0]        RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_ptr;
    logic [WAIT_W-1:0] r_wait;
    logic              r_ready;
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_fire;
    logic              w_in_range;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_accept   = (r_state == ST_IDLE) && r_ready && bus.req;
    assign w_fire     = (r_state == ST_ACCESS) && (r_wait == '0);
    assign w_in_range = ({1'b0, r_addr} < DEPTH_V);

    // The FSM owns the single array port: clear pointer during the sweep,
    // captured request otherwise. Reset gates the strobe so a held reset never writes.
    assign w_arr_we    = reset && ((r_state == ST_CLEAR) ||
                                   (w_fire && (r_rw == RW_WRITE) && w_in_range));
    assign w_arr_addr  = (r_state == ST_CLEAR) ? r_ptr[ADDR_W-1:0] : r_addr;
    assign w_arr_wdata = (r_state == ST_CLEAR) ? CLEAR_VALUE : r_wdata;

    umem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST_STATE;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_ptr   <= '0;
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wait  <= WAIT_LOAD;
                        r_state <= ST_ACCESS;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_err   <= !w_in_range;
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        // Writes leave rdata untouched; only an out-of-range access forces zero.
                        if (!w_in_range) begin
                            r_rdata <= '0;
                        end else if (r_rw == RW_READ) begin
                            r_rdata <= w_arr_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rw    <= bus.rw;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    assign bus.ready = r_ready;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_umem_ctrl.sv
// Scoreboard bench for umem_ctrl: four instances with different DEPTH/WAIT_STATES
// share one clock and reset and are exercised one at a time.
module tb_umem_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] t_req;
    logic [N-1:0] t_rw;
    logic [7:0]   t_addr  [N];
    logic [7:0]   t_wdata [N];
    logic [7:0]   t_rdata [N];
    logic [N-1:0] t_ready;
    logic [N-1:0] t_ack;
    logic [N-1:0] t_err;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // inst 0: DEPTH 16, WS 0 | inst 1: DEPTH 16, WS 3 | inst 2: DEPTH 200, WS 0 | inst 3: DEPTH 16, WS 5
    for (genvar g = 0; g < N; g++) begin : g_dut
        umem_if #(.DATA_W(8), .ADDR_W(8)) bus ();
        assign bus.req    = t_req[g];
        assign bus.rw     = t_rw[g];
        assign bus.addr   = t_addr[g];
        assign bus.wdata  = t_wdata[g];
        assign t_rdata[g] = bus.rdata;
        assign t_ready[g] = bus.ready;
        assign t_ack[g]   = bus.ack;
        assign t_err[g]   = bus.err;
        umem_ctrl #(
            .DATA_W         (8),
            .ADDR_W         (8),
            .DEPTH          ((g == 2) ? 200 : 16),
            .WAIT_STATES    ((g == 1) ? 3 : ((g == 3) ? 5 : 0)),
            .CLEAR_ON_RESET (1'b1),
            .CLEAR_VALUE    (8'h5A)
        ) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus)
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         d;
        logic       rd;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : ((d == 3) ? 5 : 0);
    endfunction

    exp_t e_mon;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (t_ack[i]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", t_ack[i], 1'b0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("ack_inst", i, e_mon.d);
                    chk("ack_cycle", cyc, e_mon.cyc);
                    chk("ack_err", t_err[i], e_mon.err);
                    if (e_mon.rd) chk("rdata", t_rdata[i], e_mon.data);
                end
            end else if (t_err[i]) begin
                chk("err_without_ack", t_err[i], 1'b0);
            end
        end
    end

    task automatic issue(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] ed, input logic ee, input bit push);
        int k;
        k = 0;
        @(negedge clk);
        while (!t_ready[d] && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!t_ready[d]) begin
            chk("ready_timeout", t_ready[d], 1'b1);
            return;
        end
        t_req[d]   = 1'b1;
        t_rw[d]    = wr;
        t_addr[d]  = a;
        t_wdata[d] = wd;
        if (push) sb.push_back('{d, !wr, ed, ee, cyc + 2 + ws_of(d)});
        @(posedge clk);
        #1 t_req[d] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("ack_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_ready", t_ready[d], 1'b0);
        chk("rst_ack",   t_ack[d],   1'b0);
        chk("rst_err",   t_err[d],   1'b0);
        chk("rst_rdata", t_rdata[d], 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        int prev;
        t_req = '0;
        t_rw  = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) chk_reset_outputs(i);

        // Clear sweep latency and contents
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        k = 0;
        while (!t_ready[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("clear_latency", cyc - c0, 16);
        for (int a = 0; a < 16; a++) issue(0, 1'b0, 8'(a), 8'h00, 8'h5A, 1'b0, 1'b1);
        issue(0, 1'b0, 8'd16, 8'h00, 8'h00, 1'b1, 1'b1);
        drain();

        // Write/read with zero wait states, then the inverted pattern
        issue(0, 1'b1, 8'h02, 8'hAA, 8'h00, 1'b0, 1'b1);
        issue(0, 1'b0, 8'h02, 8'h00, 8'hAA, 1'b0, 1'b1);
        issue(0, 1'b1, 8'h02, 8'h55, 8'h00, 1'b0, 1'b1);
        issue(0, 1'b0, 8'h02, 8'h00, 8'h55, 1'b0, 1'b1);
        drain();

        // Three wait states: ready low until the ack cycle
        issue(1, 1'b1, 8'h01, 8'h33, 8'h00, 1'b0, 1'b1);
        drain();
        issue(1, 1'b0, 8'h01, 8'h00, 8'h33, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ws_ready_low", t_ready[1], 1'b0);
        end
        @(negedge clk);
        chk("ws_ready_high", t_ready[1], 1'b1);
        chk("ws_ack", t_ack[1], 1'b1);
        drain();

        // Out of range on DEPTH=200
        issue(2, 1'b1, 8'hC8, 8'hFF, 8'h00, 1'b1, 1'b1);
        issue(2, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1, 1'b1);
        issue(2, 1'b0, 8'hC7, 8'h00, 8'h5A, 1'b0, 1'b1);
        drain();

        // Reset during a pending write: no ack, no write, sweep restarts
        issue(3, 1'b1, 8'h05, 8'h77, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs(3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, 1'b1);
        drain();

        // Back-to-back with req held high, alternating write/read on address 9
        prev = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            k = 0;
            while (!t_ready[0] && k < 60) begin
                @(negedge clk);
                k++;
            end
            if (!t_ready[0]) begin
                chk("b2b_ready_timeout", t_ready[0], 1'b1);
                break;
            end
            t_req[0]   = 1'b1;
            t_rw[0]    = (n % 2 == 0);
            t_addr[0]  = 8'h09;
            t_wdata[0] = 8'h10 + 8'(n);
            sb.push_back('{0, (n % 2 != 0), 8'h10 + 8'(n - 1), 1'b0, cyc + 2});
            if (prev >= 0) chk("b2b_accept_gap", cyc + 1 - prev, 2);
            prev = cyc + 1;
            @(posedge clk);
        end
        #1 t_req[0] = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/umem_ctrl.md
Name: umem_ctrl

Overview:
- Parametrised successor to the 8-bit CPU's user data memory.
- Replaces the tristate, negedge-write store with a request/acknowledge memory slave.
- Adds configurable wait states, out-of-range error reporting and a post-reset clear sweep.
- Sits between the CPU user-memory port and the storage array; one instance per data bank.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 256: implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- WAIT_STATES, 1: extra cycles per access, range 0..15.
- CLEAR_ON_RESET, 1: 1 = fill memory with CLEAR_VALUE after reset; 0 = skip the fill.
- CLEAR_VALUE, 0: fill value, DATA_W bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only while ready=1.
- rw  in  1  1 = write, 0 = read (CPU encoding).
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid only while ack=1.
- ready  out  1  controller idle and able to accept req.
- ack  out  1  single-cycle completion pulse.
- err  out  1  qualifies ack: address was out of range.

Behaviour:
- States: CLEAR, IDLE, ACCESS.
- While reset=0:
  - state = CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - ready=0, ack=0, err=0, rdata=0, wait counter=0, clear pointer=0.
  - Array contents are not touched asynchronously.
- CLEAR:
  - Each cycle writes CLEAR_VALUE to mem[ptr] and increments ptr.
  - At ptr=DEPTH-1 the final word is written, then state goes to IDLE.
  - Takes exactly DEPTH cycles; ready=0 throughout; req is ignored.
- IDLE:
  - ready=1.
  - When req=1 at an edge, capture addr, wdata and rw.
  - Load counter with WAIT_STATES, go to ACCESS, and drop ready on the next cycle.
- ACCESS:
  - ready=0.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access, pulse ack=1 for one cycle and return to IDLE.
  - Write: mem[addr_q] <= wdata_q at that edge.
  - Read: rdata <= mem[addr_q], registered with ack.
- Latency: ack is high in cycle N+1+WAIT_STATES after the acceptance edge N.
  - WAIT_STATES=0 gives 1-cycle latency.
  - The read/write decision uses the captured rw; inputs may change after acceptance.
- Back-to-back: ready is high in the same cycle as ack, so a req held high is accepted at the ack edge. Sustained throughput is one access per 2+WAIT_STATES cycles.
- Out of range (addr_q >= DEPTH): ack=1 and err=1, no write, rdata=0. Timing is identical to a valid access.
- rdata holds its last value outside ack, but consumers must only sample it when ack=1.
- err=0 whenever ack=0.
- Reset asserted mid-ACCESS: the pending access is abandoned and no write occurs.
  - Outputs go to their reset values immediately.
  - The clear sweep restarts after reset is released.
- Reset asserted mid-CLEAR: the sweep restarts from ptr=0 after release.
- Read-after-write to the same address: the second access returns the new data, because the write completes before the next acceptance is possible.
- Address arithmetic: ptr is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W does not wrap early.

Decomposition:
- Package umem_pkg holds:
  - the state encoding (CLEAR, IDLE, ACCESS);
  - RW_WRITE=1 and RW_READ=0;
  - the wait-counter width constant WAIT_W=4.
- One sub-module, umem_array: a single-port array of DEPTH x DATA_W.
  - Synchronous write, asynchronous read, parametrised on DATA_W, ADDR_W and DEPTH.
  - The controller's FSM owns the address/data mux between the clear pointer and the captured request.

Test Plan:
- Clear sweep: DEPTH=16, CLEAR_VALUE=8'h5A, release reset.
  - ready rises exactly 16 cycles after release.
  - Reads of addresses 0..15 all return 8'h5A, with err=0.
- Write then read: WAIT_STATES=0, write 8'hAA to 8'h02, then read 8'h02.
  - Each ack comes 1 cycle after acceptance.
  - The read returns 8'hAA.
  - The CPU NOT pattern also passes: write 8'h55, read back 8'h55.
- Wait states: WAIT_STATES=3, read address 1 after writing 8'h33 there.
  - ack arrives exactly 4 cycles after acceptance.
  - ready stays 0 for cycles 1..3 and returns to 1 with ack.
  - rdata=8'h33.
- Out of range: DEPTH=200, write 8'hFF to address 8'hC8, then read 8'hC7.
  - The write gets ack=1, err=1.
  - The read of 8'hC7 returns its clear value, err=0.
- Reset abort: start a write of 8'h77 to address 5 with WAIT_STATES=5, assert reset after 2 cycles, release, let the clear finish.
  - Reading address 5 returns CLEAR_VALUE, not 8'h77.
  - ack never pulses during the aborted access.
- Back-to-back: hold req=1 with alternating write/read to address 9, WAIT_STATES=0.
  - An accept occurs every 2 cycles.
  - Each read returns the preceding write's data.
